data_sram_responder: RTL and testbench

//  Slave (responder) end of the core's data-SRAM request/response interface.
//  EX stage issues requests; MEM stage consumes the returned word and does its own byte/half extraction.

---
 rtl/data_sram_responder_pkg.sv | 39 +++
 rtl/data_sram_responder_queue.sv | 78 +++++++
 rtl/data_sram_responder.sv | 77 +++++++
 tb/tb_data_sram_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-SRAM request/response interface, used by the
// EX-stage requester and by this responder so both pack the bus identically.
package data_sram_responder_pkg;

    typedef enum logic [1:0] {
        DSRAM_SIZE_B = 2'd0,
        DSRAM_SIZE_H = 2'd1,
        DSRAM_SIZE_W = 2'd2
    } dsram_size_e;

    // Bus packing order is {req, wr, size, addr, wstrb, wdata}.
    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dsram_req_t;

    localparam int DSRAM_REQ_BUS_WD = $bits(dsram_req_t);

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic [2:0]  wait_cnt;
    } dsram_entry_t;

    function automatic logic [31:0] dsram_merge(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  wstrb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wstrb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_queue.sv
// In-order response FIFO: each entry carries its own wait counter, which
// counts down every cycle so queued entries age while waiting behind the head.
module dsram_resp_queue
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned CNT_W       = $clog2(OUTSTANDING) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_wr,
    input  logic [31:0]      push_data,
    input  logic             pop,
    output logic             head_due,
    output logic             head_wr,
    output logic [31:0]      head_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W     = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [2:0]  WAIT_INIT = 3'(LATENCY - 1);

    dsram_entry_t     entries_q [OUTSTANDING];
    dsram_entry_t     entries_d [OUTSTANDING];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (32'(p) == OUTSTANDING - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_due  = (count_q != '0) && (entries_q[head_q].wait_cnt == 3'd0);
    assign head_wr   = entries_q[head_q].wr;
    assign head_data = entries_q[head_q].data;
    assign count     = count_q;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        for (int unsigned i = 0; i < OUTSTANDING; i++) begin
            if (entries_q[i].wait_cnt != 3'd0) begin
                entries_d[i].wait_cnt = entries_q[i].wait_cnt - 3'd1;
            end
        end
        // When full, push and pop share a slot; the head is read from entries_q so this is safe.
        if (push) begin
            entries_d[tail_q] = '{wr: push_wr, data: push_data, wait_cnt: WAIT_INIT};
            tail_d            = ptr_next(tail_q);
        end
        if (pop) begin
            head_d = ptr_next(head_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word array with byte-lane stores, loads sampled at
// accept time, and in-order responses after a fixed wait-state latency.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

    dsram_req_t        req_bus;
    logic [ADDR_W-1:0] word_idx;
    logic              accept;
    logic              head_due;
    logic              head_wr;
    logic [31:0]       head_data;
    logic [CNT_W-1:0]  count;
    logic [31:0]       mem_word;
    logic [31:0]       merged_word;
    logic              unused_bits;

    logic [31:0] mem_q [2**ADDR_W];

    assign req_bus  = {req, wr, size, addr, wstrb, wdata};
    assign word_idx = req_bus.addr[ADDR_W+1:2];
    // size is informational and the byte offset / upper address bits alias onto the same word.
    assign unused_bits = ^{req_bus.size, req_bus.addr};

    assign addr_ok = !reset && ((count < CNT_W'(OUTSTANDING)) || head_due);
    assign accept  = req_bus.req && addr_ok;
    assign data_ok = !reset && head_due;
    assign rdata   = (data_ok && !head_wr) ? head_data : 32'd0;

    assign mem_word = mem_q[word_idx];

    always_comb begin
        merged_word = dsram_merge(mem_word, req_bus.wdata, req_bus.wstrb);
    end

    always_ff @(posedge clk) begin
        if (accept && req_bus.wr) begin
            mem_q[word_idx] <= merged_word;
        end
    end

    dsram_resp_queue #(
        .OUTSTANDING (OUTSTANDING),
        .LATENCY     (LATENCY),
        .CNT_W       (CNT_W)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_wr   (req_bus.wr),
        .push_data (req_bus.wr ? 32'd0 : mem_word),
        .pop       (head_due),
        .head_due  (head_due),
        .head_wr   (head_wr),
        .head_data (head_data),
        .count     (count)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: dut_a runs LATENCY=1, dut_b runs LATENCY=3; both OUTSTANDING=2.
module tb_data_sram_responder;
    import data_sram_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_a, wr_a, addr_ok_a, data_ok_a;
    logic [1:0]  size_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  wstrb_a;

    logic        req_b, wr_b, addr_ok_b, data_ok_b;
    logic [1:0]  size_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  wstrb_b;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] BASE_B = 32'h0000_0400;

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_W(14), .LATENCY(1), .OUTSTANDING(2)) u_dut_a (
        .clk(clk), .reset(reset), .req(req_a), .wr(wr_a), .size(size_a), .addr(addr_a),
        .wstrb(wstrb_a), .wdata(wdata_a), .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a)
    );

    data_sram_responder #(.ADDR_W(14), .LATENCY(3), .OUTSTANDING(2)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .wr(wr_b), .size(size_b), .addr(addr_b),
        .wstrb(wstrb_b), .wdata(wdata_b), .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] val_b(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0011_1111;
    endfunction

    // One request on dut_a, starting from an idle cycle and ending on an idle cycle.
    task automatic a_txn(input string tag, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, input logic [31:0] exp);
        req_a = 1'b1; wr_a = w; size_a = DSRAM_SIZE_W; addr_a = a; wstrb_a = s; wdata_a = d;
        check($sformatf("%s_addr_ok", tag), 32'(addr_ok_a), 32'd1);
        step();
        req_a = 1'b0; wr_a = 1'b0; wstrb_a = 4'h0;
        check($sformatf("%s_data_ok", tag), 32'(data_ok_a), 32'd1);
        check($sformatf("%s_rdata", tag), rdata_a, exp);
        step();
        check($sformatf("%s_idle", tag), 32'(data_ok_a), 32'd0);
    endtask

    // One request on idle dut_b; waits (bounded) for the response and checks latency 3.
    task automatic b_txn(input string tag, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, input logic [31:0] exp);
        int lat;
        req_b = 1'b1; wr_b = w; size_b = DSRAM_SIZE_W; addr_b = a; wstrb_b = s; wdata_b = d;
        check($sformatf("%s_addr_ok", tag), 32'(addr_ok_b), 32'd1);
        step();
        req_b = 1'b0; wr_b = 1'b0; wstrb_b = 4'h0;
        lat = 1;
        while (data_ok_b !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        check($sformatf("%s_data_ok_seen", tag), 32'(data_ok_b), 32'd1);
        check($sformatf("%s_latency", tag), 32'(lat), 32'd3);
        check($sformatf("%s_rdata", tag), rdata_b, exp);
        step();
        check($sformatf("%s_idle", tag), 32'(data_ok_b), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req_a = 1'b0; wr_a = 1'b0; size_a = DSRAM_SIZE_W; addr_a = '0; wstrb_a = '0; wdata_a = '0;
        req_b = 1'b0; wr_b = 1'b0; size_b = DSRAM_SIZE_W; addr_b = '0; wstrb_b = '0; wdata_b = '0;
        repeat (2) step();

        check("rst_addr_ok_a", 32'(addr_ok_a), 32'd0);
        check("rst_data_ok_a", 32'(data_ok_a), 32'd0);
        check("rst_rdata_a",   rdata_a,        32'd0);
        check("rst_addr_ok_b", 32'(addr_ok_b), 32'd0);
        check("rst_data_ok_b", 32'(data_ok_b), 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_addr_ok_a", 32'(addr_ok_a), 32'd1);
        check("post_rst_data_ok_a", 32'(data_ok_a), 32'd0);

        // Store then load, latency 1.
        a_txn("t1_store", 1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'd0);
        a_txn("t1_load",  1'b0, 32'h0000_0100, 4'h0, 32'h0,        32'hDEAD_BEEF);

        // Byte-lane merge.
        a_txn("t2_store_full", 1'b1, 32'h0000_0200, 4'hF, 32'h1122_3344, 32'd0);
        a_txn("t2_store_lane", 1'b1, 32'h0000_0200, 4'h2, 32'h0000_AA00, 32'd0);
        a_txn("t2_load",       1'b0, 32'h0000_0200, 4'h0, 32'h0,         32'h1122_AA44);
        a_txn("t2_nop_store",  1'b1, 32'h0000_0200, 4'h0, 32'hFFFF_FFFF, 32'd0);
        a_txn("t2_load_again", 1'b0, 32'h0000_0200, 4'h0, 32'h0,         32'h1122_AA44);

        // Address aliasing and ignored byte offset.
        a_txn("t6_store",      1'b1, 32'h0000_0104, 4'hF, 32'h5A5A_1234, 32'd0);
        a_txn("t6_load_alias", 1'b0, 32'h0001_0104, 4'h0, 32'h0,         32'h5A5A_1234);
        a_txn("t6_load_off3",  1'b0, 32'h0000_0107, 4'h0, 32'h0,         32'h5A5A_1234);
        a_txn("t6_load_first", 1'b0, 32'h0000_0100, 4'h0, 32'h0,         32'hDEAD_BEEF);

        // Preload dut_b words used by the pipelined tests.
        for (int i = 0; i < 7; i++) begin
            b_txn($sformatf("pre%0d", i), 1'b1, BASE_B + 32'(4 * i), 4'hF, val_b(i), 32'd0);
        end

        // Three loads with req held high, latency 3.
        req_b = 1'b1; wr_b = 1'b0; addr_b = BASE_B;
        check("t3_a_addr_ok", 32'(addr_ok_b), 32'd1);
        step();
        addr_b = BASE_B + 32'd4;
        check("t3_b_addr_ok", 32'(addr_ok_b), 32'd1);
        check("t3_c1_data_ok", 32'(data_ok_b), 32'd0);
        step();
        addr_b = BASE_B + 32'd8;
        check("t3_c_stall_addr_ok", 32'(addr_ok_b), 32'd0);
        check("t3_c2_data_ok", 32'(data_ok_b), 32'd0);
        step();
        check("t3_a_data_ok", 32'(data_ok_b), 32'd1);
        check("t3_a_rdata", rdata_b, val_b(0));
        check("t3_c_addr_ok", 32'(addr_ok_b), 32'd1);
        step();
        req_b = 1'b0;
        check("t3_b_data_ok", 32'(data_ok_b), 32'd1);
        check("t3_b_rdata", rdata_b, val_b(1));
        step();
        check("t3_gap_data_ok", 32'(data_ok_b), 32'd0);
        check("t3_c5_addr_ok", 32'(addr_ok_b), 32'd1);
        step();
        check("t3_c_data_ok", 32'(data_ok_b), 32'd1);
        check("t3_c_rdata", rdata_b, val_b(2));
        step();
        check("t3_idle", 32'(data_ok_b), 32'd0);

        // Full queue: requests presented in the head's retire cycles are taken at once.
        req_b = 1'b1; addr_b = BASE_B + 32'd12;
        step();
        addr_b = BASE_B + 32'd16;
        step();
        req_b = 1'b0;
        check("t4_full_addr_ok", 32'(addr_ok_b), 32'd0);
        check("t4_full_data_ok", 32'(data_ok_b), 32'd0);
        step();
        check("t4_d_data_ok", 32'(data_ok_b), 32'd1);
        check("t4_d_rdata", rdata_b, val_b(3));
        check("t4_retire_addr_ok", 32'(addr_ok_b), 32'd1);
        req_b = 1'b1; addr_b = BASE_B + 32'd20;
        step();
        check("t4_e_data_ok", 32'(data_ok_b), 32'd1);
        check("t4_e_rdata", rdata_b, val_b(4));
        check("t4_retire2_addr_ok", 32'(addr_ok_b), 32'd1);
        addr_b = BASE_B + 32'd24;
        step();
        req_b = 1'b0;
        check("t4_count_held_addr_ok", 32'(addr_ok_b), 32'd0);
        check("t4_c5_data_ok", 32'(data_ok_b), 32'd0);
        step();
        check("t4_f_data_ok", 32'(data_ok_b), 32'd1);
        check("t4_f_rdata", rdata_b, val_b(5));
        step();
        check("t4_g_data_ok", 32'(data_ok_b), 32'd1);
        check("t4_g_rdata", rdata_b, val_b(6));
        step();
        check("t4_idle", 32'(data_ok_b), 32'd0);

        // Reset with two loads outstanding; the earlier store must survive.
        b_txn("t5_store", 1'b1, 32'h0000_0300, 4'hF, 32'hCAFE_F00D, 32'd0);
        req_b = 1'b1; wr_b = 1'b0; addr_b = BASE_B;
        check("t5_l1_addr_ok", 32'(addr_ok_b), 32'd1);
        step();
        addr_b = BASE_B + 32'd4;
        check("t5_l2_addr_ok", 32'(addr_ok_b), 32'd1);
        step();
        req_b = 1'b0; reset = 1'b1;
        #1;
        check("t5_in_rst_addr_ok", 32'(addr_ok_b), 32'd0);
        check("t5_in_rst_data_ok", 32'(data_ok_b), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("t5_post_rst_addr_ok", 32'(addr_ok_b), 32'd1);
        check("t5_post_rst_data_ok", 32'(data_ok_b), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t5_dropped_%0d", i), 32'(data_ok_b), 32'd0);
        end
        b_txn("t5_load", 1'b0, 32'h0000_0300, 4'h0, 32'h0, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
